// File: rtl/pc_pkg.sv
// Shared types for the program sequencer: FSM states, loop/one-shot modes
// and the step-operation priority decode.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    OP_INC  = 2'd0,
    OP_JMP  = 2'd1,
    OP_CALL = 2'd2,
    OP_RET  = 2'd3
  } pc_op_e;

  localparam logic MODE_LOOP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // Return beats call beats jump; with no request the address increments.
  function automatic pc_op_e pick_op(input logic ret_en, input logic call_en,
                                     input logic jmp_en);
    pc_op_e op;
    if (ret_en) begin
      op = OP_RET;
    end else if (call_en) begin
      op = OP_CALL;
    end else if (jmp_en) begin
      op = OP_JMP;
    end else begin
      op = OP_INC;
    end
    return op;
  endfunction

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO. Pushes when full and pops when empty are ignored;
// the owner decides what an overflow/underflow means.
module pc_stack
  import pc_pkg::*;
#(
  parameter int ADDR_WIDTH  = 15,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_data,
  output logic [ADDR_WIDTH-1:0] top,
  output logic                  full,
  output logic                  empty
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_d [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0] top_s;
  logic                  full_s, empty_s;

  assign full_s  = (count_q == CNT_W'(STACK_DEPTH));
  assign empty_s = (count_q == {CNT_W{1'b0}});

  // Next-state of the entry array and fill count, plus top-of-stack select.
  always_comb begin
    count_d = count_q;
    mem_d   = mem_q;
    top_s   = {ADDR_WIDTH{1'b0}};
    for (int i = 0; i < STACK_DEPTH; i++) begin
      top_s = (count_q == CNT_W'(i + 1)) ? mem_q[i] : top_s;
    end
    if (push && !full_s) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        mem_d[i] = (count_q == CNT_W'(i)) ? push_data : mem_q[i];
      end
      count_d = count_q + CNT_W'(1);
    end else if (pop && !empty_s) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Stack storage and fill count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
      for (int i = 0; i < STACK_DEPTH; i++) begin
        mem_q[i] <= {ADDR_WIDTH{1'b0}};
      end
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign top   = top_s;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/program_sequencer.sv
// Program address sequencer: steps through a program body on byte-boundary
// strobes with loop/one-shot ends, jumps, calls and returns.
module program_sequencer
  import pc_pkg::*;
#(
  parameter int ADDR_WIDTH  = 15,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stepTick,
  input  logic                  pcEn,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] loopStart,
  input  logic [ADDR_WIDTH-1:0] loopEnd,
  input  logic                  jmpEn,
  input  logic                  callEn,
  input  logic                  retEn,
  input  logic [ADDR_WIDTH-1:0] targetAddr,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  wrapPulse,
  output logic                  done,
  output logic                  stackErr
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

  pc_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, addr_d;
  logic                  wrap_pulse_q, wrap_d;
  logic                  done_q, done_d;
  logic                  stack_err_q, err_d;

  logic                  step_s;
  logic                  stk_push_s, stk_pop_s;
  logic [ADDR_WIDTH-1:0] push_data_s, stk_top_s;
  logic                  stk_full_s, stk_empty_s;

  assign step_s      = stepTick & pcEn;
  assign push_data_s = mem_addr_q + ADDR_WIDTH'(1);

  pc_stack #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (stk_push_s),
    .pop      (stk_pop_s),
    .push_data(push_data_s),
    .top      (stk_top_s),
    .full     (stk_full_s),
    .empty    (stk_empty_s)
  );

  // FSM next state, next address and stack requests for the current step.
  always_comb begin
    state_d    = state_q;
    addr_d     = mem_addr_q;
    wrap_d     = 1'b0;
    err_d      = stack_err_q;
    stk_push_s = 1'b0;
    stk_pop_s  = 1'b0;
    case (state_q)
      ST_IDLE: state_d = pcEn ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        if (step_s) begin
          case (pick_op(retEn, callEn, jmpEn))
            OP_RET: begin
              if (stk_empty_s) begin
                err_d = 1'b1;
              end else begin
                stk_pop_s = 1'b1;
                addr_d    = stk_top_s;
              end
            end
            OP_CALL: begin
              if (stk_full_s) begin
                err_d = 1'b1;
              end else begin
                stk_push_s = 1'b1;
                addr_d     = targetAddr;
              end
            end
            OP_JMP: addr_d = targetAddr;
            OP_INC: begin
              // loopEnd takes precedence over the natural address rollover.
              if (mem_addr_q == loopEnd) begin
                if (mode == MODE_LOOP) begin
                  addr_d = loopStart;
                  wrap_d = 1'b1;
                end else begin
                  state_d = ST_DONE;
                end
              end else if (mem_addr_q == ADDR_MAX) begin
                addr_d = {ADDR_WIDTH{1'b0}};
                wrap_d = 1'b1;
              end else begin
                addr_d = push_data_s;
              end
            end
            default: addr_d = mem_addr_q;
          endcase
        end else begin
          addr_d = mem_addr_q;
        end
      end
      ST_DONE: state_d = pcEn ? ST_DONE : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_DONE);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mem_addr_q   <= {ADDR_WIDTH{1'b0}};
      wrap_pulse_q <= 1'b0;
      done_q       <= 1'b0;
      stack_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= addr_d;
      wrap_pulse_q <= wrap_d;
      done_q       <= done_d;
      stack_err_q  <= err_d;
    end
  end

  assign memAddr   = mem_addr_q;
  assign wrapPulse = wrap_pulse_q;
  assign done      = done_q;
  assign stackErr  = stack_err_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: directed vector table, hand-written
// stack/reset sequences and random stimulus against a queue-based model.
module tb_program_sequencer;

  localparam int AW = 4;
  localparam int SD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stepTick = 1'b0, pcEn = 1'b0, mode = 1'b0;
  logic          jmpEn = 1'b0, callEn = 1'b0, retEn = 1'b0;
  logic [AW-1:0] loopStart = 4'd0, loopEnd = 4'd0, targetAddr = 4'd0;
  logic [AW-1:0] memAddr;
  logic          wrapPulse, done, stackErr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  program_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .rst(rst), .stepTick(stepTick), .pcEn(pcEn), .mode(mode),
    .loopStart(loopStart), .loopEnd(loopEnd), .jmpEn(jmpEn), .callEn(callEn),
    .retEn(retEn), .targetAddr(targetAddr), .memAddr(memAddr),
    .wrapPulse(wrapPulse), .done(done), .stackErr(stackErr)
  );

  // Reference model: address as plain integer arithmetic, stack as a queue.
  int m_addr;
  int m_stack[$];
  bit m_err, m_wrap, m_running, m_done;

  function void model_reset();
    m_addr = 0; m_stack.delete(); m_err = 0; m_wrap = 0; m_running = 0; m_done = 0;
  endfunction

  function void model_clock(bit st, bit en, bit md, int ls, int le, bit r, bit c, bit j, int tgt);
    m_wrap = 0;
    if (m_done) begin
      if (!en) m_done = 0;
    end else if (!m_running) begin
      if (en) m_running = 1;
    end else if (st && en) begin
      if (r) begin
        if (m_stack.size() == 0) m_err = 1;
        else m_addr = m_stack.pop_back();
      end else if (c) begin
        if (m_stack.size() == SD) m_err = 1;
        else begin
          m_stack.push_back((m_addr + 1) % (1 << AW));
          m_addr = tgt;
        end
      end else if (j) begin
        m_addr = tgt;
      end else if (m_addr == le) begin
        if (md == 0) begin m_addr = ls; m_wrap = 1; end
        else begin m_running = 0; m_done = 1; end
      end else begin
        m_addr = m_addr + 1;
        if (m_addr == (1 << AW)) begin m_addr = 0; m_wrap = 1; end
      end
    end
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string nm);
    check({nm, ".addr"}, 32'(memAddr), 32'(m_addr));
    check({nm, ".wrap"}, 32'(wrapPulse), 32'(m_wrap));
    check({nm, ".done"}, 32'(done), 32'(m_done));
    check({nm, ".err"}, 32'(stackErr), 32'(m_err));
  endtask

  task automatic do_reset();
    rst = 1'b1; stepTick = 1'b0; pcEn = 1'b0; jmpEn = 1'b0; callEn = 1'b0; retEn = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_model("reset");
  endtask

  task automatic cyc(input string nm, input bit st, input bit en, input bit md,
                     input int ls, input int le, input bit r, input bit c, input bit j,
                     input int tgt);
    stepTick = st; pcEn = en; mode = md; loopStart = AW'(ls); loopEnd = AW'(le);
    retEn = r; callEn = c; jmpEn = j; targetAddr = AW'(tgt);
    model_clock(st, en, md, ls, le, r, c, j, tgt);
    @(posedge clk); #1;
    check_model(nm);
  endtask

  typedef struct {
    bit    do_rst;
    bit    st, en, md;
    int    ls, le;
    bit    r, c, j;
    int    tgt;
    int    e_addr;
    bit    e_wrap, e_done, e_err;
    string nm;
  } vec_t;

  vec_t tbl[$];

  function void add(string nm, bit do_rst, bit st, bit en, bit md, int ls, int le,
                    bit r, bit c, bit j, int tgt, int e_addr, bit e_wrap, bit e_done, bit e_err);
    vec_t v;
    v.nm = nm; v.do_rst = do_rst; v.st = st; v.en = en; v.md = md; v.ls = ls; v.le = le;
    v.r = r; v.c = c; v.j = j; v.tgt = tgt;
    v.e_addr = e_addr; v.e_wrap = e_wrap; v.e_done = e_done; v.e_err = e_err;
    tbl.push_back(v);
  endfunction

  initial begin
    // Loop mode 3..5
    add("loop_arm", 1, 0, 1, 0, 3, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    add("loop_s1",  0, 1, 1, 0, 3, 5, 0, 0, 0, 0, 1, 0, 0, 0);
    add("loop_s2",  0, 1, 1, 0, 3, 5, 0, 0, 0, 0, 2, 0, 0, 0);
    add("loop_s3",  0, 1, 1, 0, 3, 5, 0, 0, 0, 0, 3, 0, 0, 0);
    add("loop_s4",  0, 1, 1, 0, 3, 5, 0, 0, 0, 0, 4, 0, 0, 0);
    add("loop_s5",  0, 1, 1, 0, 3, 5, 0, 0, 0, 0, 5, 0, 0, 0);
    add("loop_s6",  0, 1, 1, 0, 3, 5, 0, 0, 0, 0, 3, 1, 0, 0);
    add("loop_s7",  0, 1, 1, 0, 3, 5, 0, 0, 0, 0, 4, 0, 0, 0);
    add("loop_frz", 0, 1, 0, 0, 3, 5, 0, 0, 0, 0, 4, 0, 0, 0);
    // One-shot ending at 2
    add("os_arm",   1, 0, 1, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    add("os_s1",    0, 1, 1, 1, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0);
    add("os_s2",    0, 1, 1, 1, 0, 2, 0, 0, 0, 0, 2, 0, 0, 0);
    add("os_s3",    0, 1, 1, 1, 0, 2, 0, 0, 0, 0, 2, 0, 1, 0);
    add("os_s4",    0, 1, 1, 1, 0, 2, 0, 0, 1, 9, 2, 0, 1, 0);
    add("os_idle",  0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 2, 0, 0, 0);
    add("os_ignor", 0, 1, 0, 1, 0, 2, 0, 0, 0, 0, 2, 0, 0, 0);
    // Call/return, priority and rollover
    add("cr_arm",   1, 0, 1, 0, 0, 15, 0, 0, 0, 0, 0, 0, 0, 0);
    add("cr_jmp4",  0, 1, 1, 0, 0, 15, 0, 0, 1, 4, 4, 0, 0, 0);
    add("cr_call9", 0, 1, 1, 0, 0, 15, 0, 1, 0, 9, 9, 0, 0, 0);
    add("cr_inc",   0, 1, 1, 0, 0, 15, 0, 0, 0, 0, 10, 0, 0, 0);
    add("cr_ret",   0, 1, 1, 0, 0, 15, 1, 0, 0, 0, 5, 0, 0, 0);
    add("cr_call12",0, 1, 1, 0, 0, 15, 0, 1, 0, 12, 12, 0, 0, 0);
    add("pri_all",  0, 1, 1, 0, 0, 15, 1, 1, 1, 1, 6, 0, 0, 0);
    add("ro_jmp15", 0, 1, 1, 0, 0, 3, 0, 0, 1, 15, 15, 0, 0, 0);
    add("ro_roll",  0, 1, 1, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0);
    add("ro_next",  0, 1, 1, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0);

    do_reset();
    foreach (tbl[k]) begin
      if (tbl[k].do_rst) do_reset();
      cyc(tbl[k].nm, tbl[k].st, tbl[k].en, tbl[k].md, tbl[k].ls, tbl[k].le,
          tbl[k].r, tbl[k].c, tbl[k].j, tbl[k].tgt);
      check({tbl[k].nm, ".vaddr"}, 32'(memAddr), 32'(tbl[k].e_addr));
      check({tbl[k].nm, ".vwrap"}, 32'(wrapPulse), 32'(tbl[k].e_wrap));
      check({tbl[k].nm, ".vdone"}, 32'(done), 32'(tbl[k].e_done));
      check({tbl[k].nm, ".verr"}, 32'(stackErr), 32'(tbl[k].e_err));
    end

    // Stack overflow then underflow; the error flag is sticky until reset.
    do_reset();
    cyc("se_arm", 0, 1, 0, 0, 15, 0, 0, 0, 0);
    cyc("se_call1", 1, 1, 0, 0, 15, 0, 1, 0, 1);
    cyc("se_call2", 1, 1, 0, 0, 15, 0, 1, 0, 2);
    cyc("se_call3", 1, 1, 0, 0, 15, 0, 1, 0, 7);
    check("se_ovf_addr", 32'(memAddr), 32'd2);
    check("se_ovf_err", 32'(stackErr), 32'd1);
    cyc("se_ret1", 1, 1, 0, 0, 15, 1, 0, 0, 0);
    check("se_ret1_addr", 32'(memAddr), 32'd2);
    cyc("se_ret2", 1, 1, 0, 0, 15, 1, 0, 0, 0);
    check("se_ret2_addr", 32'(memAddr), 32'd1);
    cyc("se_ret3", 1, 1, 0, 0, 15, 1, 0, 0, 0);
    cyc("se_ret4", 1, 1, 0, 0, 15, 1, 0, 0, 0);
    check("se_unf_addr", 32'(memAddr), 32'd1);
    cyc("se_hold", 0, 0, 0, 0, 15, 0, 0, 0, 0);
    check("se_sticky", 32'(stackErr), 32'd1);
    do_reset();
    check("se_clr", 32'(stackErr), 32'd0);

    // Asynchronous reset between edges at address 7, with a stacked return.
    cyc("ar_arm", 0, 1, 0, 0, 15, 0, 0, 0, 0);
    cyc("ar_call7", 1, 1, 0, 0, 15, 0, 1, 0, 7);
    check("ar_pre", 32'(memAddr), 32'd7);
    #2 rst = 1'b1;
    #1;
    check("ar_async_addr", 32'(memAddr), 32'd0);
    check("ar_async_err", 32'(stackErr), 32'd0);
    check("ar_async_done", 32'(done), 32'd0);
    stepTick = 1'b1; pcEn = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_model("ar_hold");
    cyc("ar_rearm", 0, 1, 0, 0, 15, 0, 0, 0, 0);
    cyc("ar_ret_empty", 1, 1, 0, 0, 15, 1, 0, 0, 0);
    check("ar_empty_err", 32'(stackErr), 32'd1);
    cyc("ar_first", 1, 1, 0, 0, 15, 0, 0, 0, 0);
    check("ar_first_addr", 32'(memAddr), 32'd1);

    // Random stimulus against the model.
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 0) do_reset();
      cyc("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 5) == 0), int'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 15, SHALL set the program address width (covers at least 20480 words).
REQ-002 Parameter STACK_DEPTH, default 4, SHALL set the number of return-address stack entries (at least 1).
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 stepTick  input  1  SHALL be the one-clk-wide step strobe (byte-boundary pulse).
REQ-006 pcEn  input  1  SHALL be the sequencer enable.
REQ-007 mode  input  1  SHALL select 0 = loop, 1 = one-shot.
REQ-008 loopStart  input  ADDR_WIDTH  SHALL be the loop re-entry address.
REQ-009 loopEnd  input  ADDR_WIDTH  SHALL be the last address of the program body.
REQ-010 jmpEn, callEn, retEn  input  1 each  SHALL request a jump, call or return on the next step.
REQ-011 targetAddr  input  ADDR_WIDTH  SHALL be the jump/call destination.
REQ-012 memAddr  output  ADDR_WIDTH  SHALL be the current program address (registered).
REQ-013 wrapPulse  output  1  SHALL pulse for one clk when a loop wrap occurs.
REQ-014 done  output  1  SHALL be high while in DONE.
REQ-015 stackErr  output  1  SHALL be the sticky overflow/underflow flag.

Function
REQ-016 State machine states SHALL be IDLE, RUN and DONE.
REQ-017 IDLE -> RUN SHALL occur on the first clk with pcEn=1; memAddr SHALL be unchanged on that transition.
REQ-018 In RUN, memAddr SHALL change only on a clk with stepTick=1 and pcEn=1 (a "step"); the new value SHALL be visible the following cycle.
REQ-019 Step priority SHALL be retEn > callEn > jmpEn > sequential increment.
REQ-020 ret: memAddr SHALL take the popped stack top; on an empty stack, memAddr SHALL hold and stackErr SHALL set.
REQ-021 call: memAddr+1 (mod 2^ADDR_WIDTH) SHALL be pushed and memAddr SHALL take targetAddr; on a full stack, nothing SHALL be pushed, memAddr SHALL hold and stackErr SHALL set.
REQ-022 jmp: memAddr SHALL take targetAddr with no stack change.
REQ-023 Increment with memAddr==loopEnd, mode=0: memAddr SHALL take loopStart and wrapPulse SHALL assert for one clk.
REQ-024 Increment with memAddr==loopEnd, mode=1: memAddr SHALL hold and the state SHALL go to DONE.
REQ-025 Increment at 2^ADDR_WIDTH-1 without reaching loopEnd: memAddr SHALL roll to 0 and wrapPulse SHALL assert.
REQ-026 loopStart, loopEnd and mode SHALL be sampled only at the step that uses them.
REQ-027 In DONE, steps SHALL be ignored; pcEn=0 SHALL return to IDLE with memAddr held.
REQ-028 pcEn=0 in RUN SHALL freeze memAddr and the stack; the state SHALL remain RUN.
REQ-029 stepTick outside RUN SHALL have no effect.

Reset
REQ-030 rst=1 SHALL force IDLE, memAddr=0, wrapPulse=0, done=0, stackErr=0 and the stack empty, regardless of clk.
REQ-031 Reset asserted mid-step SHALL discard the step; the first post-reset step SHALL start from address 0.
REQ-032 stackErr SHALL clear only on reset.

Structure
REQ-033 Package pc_pkg SHALL hold the state encoding and the MODE_LOOP/MODE_ONESHOT constants.
REQ-034 The return stack SHALL be the sub-module pc_stack (LIFO, parameters ADDR_WIDTH and STACK_DEPTH, with full/empty outputs).

Verification (ADDR_WIDTH=4, STACK_DEPTH=2)
REQ-035 Loop: loopStart=3, loopEnd=5, mode=0, 7 steps from 0 -> 1,2,3,4,5,3,4; wrapPulse once, after the 5->3 step.
REQ-036 One-shot: loopEnd=2, mode=1, 4 steps -> 1,2,2,2; done=1 after the 3rd step; pcEn=0 -> IDLE, done=0.
REQ-037 Call/return: at addr 4, call target 9 -> 9; step -> 10; ret -> 5; stackErr=0.
REQ-038 Stack errors: 3 nested calls -> 3rd holds memAddr, stackErr=1; 3 rets then 1 extra ret -> memAddr holds; stackErr stays 1 until rst.
REQ-039 Priority and rollover: retEn, callEn and jmpEn asserted on one step -> ret taken; loopEnd=3, loopStart=0 reached from 15 -> 0 with wrapPulse.
REQ-040 Async reset: rst asserted between clk edges at memAddr=7 -> memAddr=0 immediately, stack empty, IDLE.
